// File: rtl/mips_bus_pkg.sv
// Types and constants shared by the mips_cpu_bus masters and slaves.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
    } ram_state_t;

    localparam logic [31:0] RESET_VECTOR   = 32'hBFC00000;
    localparam int          BUS_DATA_WIDTH = 32;

endpackage

// File: rtl/mips_bus_ram_core.sv
// Word-addressed RAM array: byte-masked synchronous write, registered read port
// with a clear input so the controller can force readdata to zero.
module mips_bus_ram_core
    import mips_bus_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    IDX_W       = 10,
    parameter string INIT_FILE   = ""
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_we,
    input  logic                        i_re,
    input  logic                        i_clr,
    input  logic [IDX_W-1:0]            i_idx,
    input  logic [BUS_DATA_WIDTH/8-1:0] i_be,
    input  logic [BUS_DATA_WIDTH-1:0]   i_wdata,
    output logic [BUS_DATA_WIDTH-1:0]   o_rdata
);

    logic [BUS_DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
    logic [BUS_DATA_WIDTH-1:0] r_rdata;

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
            r_mem[i] = '0;
        end
    end

    // Memory contents deliberately survive reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < BUS_DATA_WIDTH / 8; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_clr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mips_bus_ram_model.sv
// Avalon-style RAM slave for the mips_cpu_bus: programmable waitrequest stalls,
// address window decode and a one-cycle err pulse for illegal accesses.
module mips_bus_ram_model
    import mips_bus_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(RESET_VECTOR),
    parameter int                    WAIT_CYCLES = 0,
    parameter string                 INIT_FILE   = ""
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     address,
    input  logic                      read,
    input  logic                      write,
    input  logic [DATA_WIDTH-1:0]     writedata,
    input  logic [DATA_WIDTH/8-1:0]   byteenable,
    output logic [DATA_WIDTH-1:0]     readdata,
    output logic                      waitrequest,
    output logic                      err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [7:0] CNT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    ram_state_t            r_state;
    ram_state_t            w_state_next;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_next;
    logic                  r_err;
    logic                  w_req;
    logic                  w_wait;
    logic                  w_go;
    logic                  w_accept;
    logic                  w_legal;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_req = read | write;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_wait       = 1'b0;
        w_go         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_CYCLES == 0) begin
                        w_go = 1'b1;
                    end else begin
                        w_wait       = 1'b1;
                        w_state_next = WAIT;
                        w_cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                // A master dropping its request mid-stall simply abandons the access.
                if (!w_req) begin
                    w_state_next = IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_go         = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_wait     = 1'b1;
                    w_cnt_next = r_cnt - 8'd1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_accept & ~w_legal;
        end
    end

    // Below-base addresses wrap to huge indices, so one compare covers both ends.
    assign w_offset = address - BASE_ADDR;
    assign w_idx    = w_offset >> 2;
    assign w_legal  = (w_idx < ADDR_WIDTH'(DEPTH_WORDS)) && (address[1:0] == 2'b00)
                      && !(read && write);
    assign w_accept = w_go & reset;

    mips_bus_ram_core #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .INIT_FILE   (INIT_FILE)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_accept & w_legal & write),
        .i_re    (w_accept & w_legal & read),
        .i_clr   (w_accept & ~w_legal & read),
        .i_idx   (w_idx[IDX_W-1:0]),
        .i_be    (byteenable),
        .i_wdata (writedata),
        .o_rdata (w_rdata)
    );

    assign readdata    = w_rdata;
    assign waitrequest = w_wait;
    assign err         = r_err;

endmodule

// File: tb/tb_mips_bus_ram_model.sv
// Scoreboard bench: three RAM instances (0, 3 and 4 wait cycles) exercised with
// directed accesses; a per-instance monitor checks err/readdata after each accept.
module tb_mips_bus_ram_model;
    import mips_bus_pkg::*;

    localparam int          N    = 3;
    localparam logic [31:0] BASE = 32'hBFC00000;

    function automatic int wc_of(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        int          dut;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic [31:0] rdata [N];
    logic [3:0]  be    [N];
    logic        rd    [N];
    logic        wr    [N];
    logic        wreq  [N];
    logic        err   [N];

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    task automatic check32(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", nm, d, act, exp);
        end
    endtask

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            mips_bus_ram_model #(
                .DATA_WIDTH  (32),
                .ADDR_WIDTH  (32),
                .DEPTH_WORDS (1024),
                .BASE_ADDR   (BASE),
                .WAIT_CYCLES (wc_of(gi)),
                .INIT_FILE   ("")
            ) u_dut (
                .clk         (clk),
                .reset       (rst_n[gi]),
                .address     (addr[gi]),
                .read        (rd[gi]),
                .write       (wr[gi]),
                .writedata   (wdata[gi]),
                .byteenable  (be[gi]),
                .readdata    (rdata[gi]),
                .waitrequest (wreq[gi]),
                .err         (err[gi])
            );

            logic acc_g;
            exp_t e_g;

            // Sample the handshake just before the edge, check outputs just after it.
            always @(negedge clk) begin
                #4;
                acc_g = mon_en && rst_n[gi] && (rd[gi] || wr[gi]) && !wreq[gi];
                @(posedge clk);
                #1;
                if (acc_g) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL sb_empty dut%0d: got an accept, expected none", gi);
                    end else begin
                        e_g = exp_q.pop_front();
                        check32("sb_dut", gi, 32'(gi), 32'(e_g.dut));
                        check32("err", gi, {31'd0, err[gi]}, {31'd0, e_g.exp_err});
                        if (e_g.chk_rd) check32("readdata", gi, rdata[gi], e_g.exp_rd);
                        $display("[TB] dut%0d t=%0t addr=%h rd=%0b wr=%0b err=%0b readdata=%h",
                                 gi, $time, addr[gi], rd[gi], wr[gi], err[gi], rdata[gi]);
                    end
                end else if (mon_en && rst_n[gi]) begin
                    check32("err_idle", gi, {31'd0, err[gi]}, 32'd0);
                end
            end
        end
    endgenerate

    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] b, input logic e_err,
                          input logic chk, input logic [31:0] e_rd);
        exp_t e;
        int   stalls;
        e.dut = d; e.exp_err = e_err; e.chk_rd = chk; e.exp_rd = e_rd;
        exp_q.push_back(e);
        @(negedge clk);
        addr[d] = a; wdata[d] = wd; be[d] = b; rd[d] = r; wr[d] = w;
        stalls = 0;
        #1;
        while (wreq[d] && stalls < 300) begin
            stalls++;
            @(negedge clk);
            #1;
        end
        check32("stall_cycles", d, 32'(stalls), 32'(wc_of(d)));
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            rst_n[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0; rd[i] = 1'b0; wr[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            check32("rst_readdata", i, rdata[i], 32'd0);
            check32("rst_err", i, {31'd0, err[i]}, 32'd0);
            check32("rst_waitreq", i, {31'd0, wreq[i]}, 32'd0);
        end
        mon_en = 1'b1;

        // Zero-wait instance: preload, read, back-to-back, boundaries, illegal accesses.
        access(0, 0, 1, BASE, 32'h24020005, 4'hF, 0, 0, 32'h0);
        access(0, 1, 0, BASE, 32'h0, 4'h0, 0, 1, 32'h24020005);
        access(0, 0, 1, BASE + 32'h0, 32'hA0A0A0A0, 4'hF, 0, 0, 32'h0);
        access(0, 0, 1, BASE + 32'h4, 32'hA1A1A1A1, 4'hF, 0, 0, 32'h0);
        access(0, 0, 1, BASE + 32'h8, 32'hA2A2A2A2, 4'hF, 0, 0, 32'h0);
        access(0, 0, 1, BASE + 32'hC, 32'hA3A3A3A3, 4'hF, 0, 0, 32'h0);
        access(0, 1, 0, BASE + 32'h0, 32'h0, 4'h0, 0, 1, 32'hA0A0A0A0);
        access(0, 1, 0, BASE + 32'h4, 32'h0, 4'h0, 0, 1, 32'hA1A1A1A1);
        access(0, 1, 0, BASE + 32'h8, 32'h0, 4'h0, 0, 1, 32'hA2A2A2A2);
        access(0, 1, 0, BASE + 32'hC, 32'h0, 4'h0, 0, 1, 32'hA3A3A3A3);
        access(0, 0, 1, BASE + 32'h20, 32'h0BADF00D, 4'hF, 0, 0, 32'h0);
        access(0, 1, 0, BASE + 32'h20, 32'h0, 4'h0, 0, 1, 32'h0BADF00D);
        access(0, 0, 1, BASE + 32'hFFC, 32'h55AA55AA, 4'hF, 0, 0, 32'h0);
        access(0, 1, 0, BASE + 32'hFFC, 32'h0, 4'h0, 0, 1, 32'h55AA55AA);
        access(0, 1, 0, BASE + 32'h2, 32'h0, 4'h0, 1, 1, 32'h0);
        access(0, 0, 1, BASE + 32'h1000, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0);
        access(0, 1, 0, BASE, 32'h0, 4'h0, 0, 1, 32'hA0A0A0A0);
        access(0, 1, 1, BASE + 32'h4, 32'h77777777, 4'hF, 1, 1, 32'h0);
        access(0, 1, 0, BASE + 32'h4, 32'h0, 4'h0, 0, 1, 32'hA1A1A1A1);
        access(0, 1, 0, BASE - 32'h4, 32'h0, 4'h0, 1, 1, 32'h0);
        idle(0);

        // Three-wait instance: byte-lane masked write over a known word.
        access(1, 0, 1, BASE + 32'h10, 32'h11223344, 4'hF, 0, 0, 32'h0);
        access(1, 0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'b0101, 0, 0, 32'h0);
        access(1, 1, 0, BASE + 32'h10, 32'h0, 4'h0, 0, 1, 32'h11AD33EF);
        idle(1);

        // Four-wait instance: reset in the second stall cycle aborts the write.
        access(2, 0, 1, BASE + 32'h8, 32'h12345678, 4'hF, 0, 0, 32'h0);
        @(negedge clk);
        addr[2] = BASE + 32'h8; wdata[2] = 32'hCAFEF00D; be[2] = 4'hF; rd[2] = 1'b0; wr[2] = 1'b1;
        #1 check32("abort_wait1", 2, {31'd0, wreq[2]}, 32'd1);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1 check32("abort_wait2", 2, {31'd0, wreq[2]}, 32'd1);
        @(negedge clk);
        rst_n[2] = 1'b1;
        wr[2]    = 1'b0;
        #1;
        check32("abort_waitreq", 2, {31'd0, wreq[2]}, 32'd0);
        check32("abort_readdata", 2, rdata[2], 32'd0);
        check32("abort_err", 2, {31'd0, err[2]}, 32'd0);
        access(2, 1, 0, BASE + 32'h8, 32'h0, 4'h0, 0, 1, 32'h12345678);
        idle(2);

        repeat (3) @(negedge clk);
        check32("sb_drained", 0, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
